// File: rtl/axi_rd_chk_pkg.sv
// Shared types for the AXI read ordering checker: error codes and the
// sticky-vector helper.
package axi_rd_chk_pkg;

    localparam int ERR_CODE_WIDTH = 3;
    localparam int STICKY_WIDTH   = 5;

    typedef enum logic [ERR_CODE_WIDTH-1:0] {
        ERR_NONE         = 3'd0,
        ERR_UNEXPECTED   = 3'd1,
        ERR_EARLY_LAST   = 3'd2,
        ERR_MISSING_LAST = 3'd3,
        ERR_OVERFLOW     = 3'd4,
        ERR_TIMEOUT      = 3'd5
    } err_code_t;

    // Sticky bit for a code: bit (code-1), nothing for ERR_NONE.
    function automatic logic [STICKY_WIDTH-1:0] code_bit(input err_code_t c);
        logic [STICKY_WIDTH-1:0] b;
        b = '0;
        if (c != ERR_NONE) b = STICKY_WIDTH'(1) << (c - 3'd1);
        return b;
    endfunction

endpackage

// File: rtl/axi_rd_len_fifo.sv
// Per-ID FIFO of outstanding burst lengths. Pointers carry one extra bit so
// full and empty are told apart after wrapping.
module axi_rd_len_fifo
    import axi_rd_chk_pkg::*;
#(
    parameter int LEN_WIDTH = 8,
    parameter int DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic                 pop,
    input  logic [LEN_WIDTH-1:0] din,
    output logic [LEN_WIDTH-1:0] head,
    output logic                 full,
    output logic                 empty
);
    localparam int AW = $clog2(DEPTH);

    logic [LEN_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]          wr_ptr, rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    // Pointer update; push into a full FIFO and pop from an empty one are ignored.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since empty masks them.
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/axi_rd_order_checker.sv
// Passive AXI read-channel ordering checker. Tracks outstanding bursts per
// ARID and checks R beat count / RLAST placement in per-ID order.
// Optional watchdog: define AXI_RD_CHK_TIMEOUT_EN.
module axi_rd_order_checker
    import axi_rd_chk_pkg::*;
#(
    parameter int ID_WIDTH       = 4,
    parameter int LEN_WIDTH      = 8,
    parameter int PER_ID_DEPTH   = 4,
    parameter int RESP_WIDTH     = 2,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ar_valid,
    input  logic                    ar_ready,
    input  logic [ID_WIDTH-1:0]     ar_id,
    input  logic [LEN_WIDTH-1:0]    ar_len,
    input  logic                    r_valid,
    input  logic                    r_ready,
    input  logic [ID_WIDTH-1:0]     r_id,
    input  logic                    r_last,
    input  logic [RESP_WIDTH-1:0]   r_resp,
    input  logic                    err_clear,
    output logic                    err_valid,
    output logic [ERR_CODE_WIDTH-1:0] err_code,
    output logic [ID_WIDTH-1:0]     err_id,
    output logic [STICKY_WIDTH-1:0] err_sticky,
    output logic [$clog2((2**ID_WIDTH)*PER_ID_DEPTH+1)-1:0] outstanding,
    output logic [15:0]             resp_err_cnt
);
    localparam int NUM_IDS = 2**ID_WIDTH;
    localparam int OUT_W   = $clog2(NUM_IDS*PER_ID_DEPTH+1);

    logic ar_hs, r_hs;
    assign ar_hs = ar_valid && ar_ready;
    assign r_hs  = r_valid && r_ready;

    logic [NUM_IDS-1:0]                push, pop, full, empty;
    logic [NUM_IDS-1:0][LEN_WIDTH-1:0] head;
    logic [NUM_IDS-1:0][LEN_WIDTH-1:0] beat_cnt;

    for (genvar i = 0; i < NUM_IDS; i++) begin : g_id
        logic r_sel;
        assign r_sel   = r_hs && (r_id == ID_WIDTH'(i));
        // Push only into a FIFO that had space before this cycle.
        assign push[i] = ar_hs && (ar_id == ID_WIDTH'(i)) && !full[i];
        // A burst retires on RLAST or on its final beat, right or wrong.
        assign pop[i]  = r_sel && !empty[i] && (r_last || (beat_cnt[i] == head[i]));

        axi_rd_len_fifo #(
            .LEN_WIDTH (LEN_WIDTH),
            .DEPTH     (PER_ID_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[i]),
            .pop   (pop[i]),
            .din   (ar_len),
            .head  (head[i]),
            .full  (full[i]),
            .empty (empty[i])
        );

        // Beat position within the head burst of this ID.
        always_ff @(posedge clk) begin
            if (!rst)                 beat_cnt[i] <= '0;
            else if (pop[i])          beat_cnt[i] <= '0;
            else if (r_sel && !empty[i]) beat_cnt[i] <= beat_cnt[i] + 1'b1;
        end
    end

    // R beat classification against pre-cycle state of its ID.
    err_code_t r_code;
    logic      r_err;
    always_comb begin
        r_err  = 1'b0;
        r_code = ERR_NONE;
        if (r_hs) begin
            if (empty[r_id]) begin
                r_err  = 1'b1;
                r_code = ERR_UNEXPECTED;
            end else if (r_last && (beat_cnt[r_id] != head[r_id])) begin
                r_err  = 1'b1;
                r_code = ERR_EARLY_LAST;
            end else if (!r_last && (beat_cnt[r_id] == head[r_id])) begin
                r_err  = 1'b1;
                r_code = ERR_MISSING_LAST;
            end
        end
    end

    logic ovf;
    assign ovf = ar_hs && full[ar_id];

    logic tmo;
`ifdef AXI_RD_CHK_TIMEOUT_EN
    logic [31:0] wd_cnt, wd_nxt;
    assign wd_nxt = wd_cnt + 32'd1;
    assign tmo    = r_hs == 1'b0 && outstanding != '0 && wd_nxt == 32'(TIMEOUT_CYCLES);

    // Watchdog: counts cycles with work pending but no R traffic.
    always_ff @(posedge clk) begin
        if (!rst)                          wd_cnt <= '0;
        else if (r_hs || outstanding == '0) wd_cnt <= '0;
        else if (tmo)                      wd_cnt <= '0;
        else                               wd_cnt <= wd_nxt;
    end
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = ^32'(TIMEOUT_CYCLES);
    assign tmo = 1'b0;
`endif

    // Priority select and sticky accumulation for this cycle's errors.
    err_code_t               sel_code;
    logic [ID_WIDTH-1:0]     sel_id;
    logic [STICKY_WIDTH-1:0] raised;
    always_comb begin
        sel_code = ERR_NONE;
        sel_id   = '0;
        raised   = '0;
        if (r_err) raised = raised | code_bit(r_code);
        if (ovf)   raised = raised | code_bit(ERR_OVERFLOW);
        if (tmo)   raised = raised | code_bit(ERR_TIMEOUT);
        if (r_err) begin
            sel_code = r_code;
            sel_id   = r_id;
        end else if (ovf) begin
            sel_code = ERR_OVERFLOW;
            sel_id   = ar_id;
        end else if (tmo) begin
            sel_code = ERR_TIMEOUT;
        end
    end

    // Registered error report and status counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_valid    <= 1'b0;
            err_code     <= '0;
            err_id       <= '0;
            err_sticky   <= '0;
            outstanding  <= '0;
            resp_err_cnt <= '0;
        end else begin
            err_valid   <= (raised != '0);
            err_code    <= sel_code;
            err_id      <= sel_id;
            err_sticky  <= (err_clear ? '0 : err_sticky) | raised;
            outstanding <= outstanding + OUT_W'(|push) - OUT_W'(|pop);
            if (r_hs && (r_resp != '0) && (resp_err_cnt != 16'hFFFF))
                resp_err_cnt <= resp_err_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_axi_rd_order_checker.sv
// Self-checking bench for axi_rd_order_checker: queue-based reference model
// compared every cycle, plus directed scenarios with literal expectations.
// Define AXI_RD_CHK_TIMEOUT_EN to also exercise the watchdog (limit 20).
module tb_axi_rd_order_checker;
    localparam int IDW = 4, LENW = 8, DEPTH = 4, RESPW = 2, TMO = 20;
    localparam int NIDS = 2**IDW;
    localparam int OUTW = $clog2(NIDS*DEPTH+1);

    logic clk, rst;
    logic ar_valid, ar_ready, r_valid, r_ready, r_last, err_clear;
    logic [IDW-1:0]   ar_id, r_id;
    logic [LENW-1:0]  ar_len;
    logic [RESPW-1:0] r_resp;
    logic             err_valid;
    logic [2:0]       err_code;
    logic [IDW-1:0]   err_id;
    logic [4:0]       err_sticky;
    logic [OUTW-1:0]  outstanding;
    logic [15:0]      resp_err_cnt;

    axi_rd_order_checker #(
        .ID_WIDTH(IDW), .LEN_WIDTH(LENW), .PER_ID_DEPTH(DEPTH),
        .RESP_WIDTH(RESPW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_id(ar_id), .ar_len(ar_len),
        .r_valid(r_valid), .r_ready(r_ready), .r_id(r_id), .r_last(r_last),
        .r_resp(r_resp), .err_clear(err_clear),
        .err_valid(err_valid), .err_code(err_code), .err_id(err_id),
        .err_sticky(err_sticky), .outstanding(outstanding), .resp_err_cnt(resp_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0, fails = 0;

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int mq [NIDS][$];
    int mc [NIDS];
    int m_valid, m_code, m_id, m_sticky, m_out, m_resp, m_idle;
    bit started = 0;

    task automatic model_step();
        int rcode, pre_ar_size, bits, L;
        bit ovf, tmo;
        started = 1;
        if (!rst) begin
            for (int i = 0; i < NIDS; i++) begin mq[i].delete(); mc[i] = 0; end
            m_valid = 0; m_code = 0; m_id = 0; m_sticky = 0; m_out = 0; m_resp = 0; m_idle = 0;
            return;
        end
        rcode = 0; ovf = 0; tmo = 0; bits = 0;
        pre_ar_size = mq[int'(ar_id)].size();
        if (r_valid && r_ready) begin
            int id = int'(r_id);
            if (mq[id].size() == 0) rcode = 1;
            else begin
                L = mq[id][0];
                if (mc[id] == L || r_last) begin
                    if (r_last && mc[id] < L) rcode = 2;
                    else if (!r_last) rcode = 3;
                    void'(mq[id].pop_front());
                    mc[id] = 0;
                end else mc[id]++;
            end
            if (r_resp != 0 && m_resp < 65535) m_resp++;
        end
        if (ar_valid && ar_ready) begin
            if (pre_ar_size >= DEPTH) ovf = 1;
            else mq[int'(ar_id)].push_back(int'(ar_len));
        end
`ifdef AXI_RD_CHK_TIMEOUT_EN
        if ((r_valid && r_ready) || m_out == 0) m_idle = 0;
        else begin
            m_idle++;
            if (m_idle == TMO) begin tmo = 1; m_idle = 0; end
        end
`endif
        if (rcode != 0) bits |= 1 << (rcode - 1);
        if (ovf) bits |= 1 << 3;
        if (tmo) bits |= 1 << 4;
        m_valid = (bits != 0);
        if (rcode != 0)  begin m_code = rcode; m_id = int'(r_id); end
        else if (ovf)    begin m_code = 4; m_id = int'(ar_id); end
        else if (tmo)    begin m_code = 5; m_id = 0; end
        else             begin m_code = 0; m_id = 0; end
        m_sticky = (err_clear ? 0 : m_sticky) | bits;
        m_out = 0;
        for (int i = 0; i < NIDS; i++) m_out += mq[i].size();
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle compare, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (started) begin
            chk("m_err_valid",   int'(err_valid),    m_valid);
            chk("m_err_code",    int'(err_code),     m_code);
            chk("m_err_id",      int'(err_id),       m_id);
            chk("m_err_sticky",  int'(err_sticky),   m_sticky);
            chk("m_outstanding", int'(outstanding),  m_out);
            chk("m_resp_cnt",    int'(resp_err_cnt), m_resp);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk); #1;
        ar_valid = 0; r_valid = 0; err_clear = 0; r_resp = 0; r_last = 0;
    endtask
    task automatic ar(input int id, input int len);
        ar_valid = 1; ar_id = IDW'(id); ar_len = LENW'(len);
    endtask
    task automatic rb(input int id, input bit last, input int resp = 0);
        r_valid = 1; r_id = IDW'(id); r_last = last; r_resp = RESPW'(resp);
    endtask

    initial begin
        int n;
        rst = 0; ar_valid = 0; ar_ready = 1; ar_id = 0; ar_len = 0;
        r_valid = 0; r_ready = 1; r_id = 0; r_last = 0; r_resp = 0; err_clear = 0;
        repeat (3) step();
        chk("rst_err_valid", int'(err_valid), 0);
        chk("rst_err_code", int'(err_code), 0);
        chk("rst_sticky", int'(err_sticky), 0);
        chk("rst_outstanding", int'(outstanding), 0);
        chk("rst_resp_cnt", int'(resp_err_cnt), 0);
        rst = 1; step();

        // Single-beat burst
        ar(0, 0); step();
        chk("t1_out1", int'(outstanding), 1);
        rb(0, 1); step();
        chk("t1_out0", int'(outstanding), 0);
        chk("t1_noerr", int'(err_valid), 0);

        // Four-beat burst, then a one-beat burst proves counter went back to 0
        ar(5, 3); step();
        for (int b = 0; b < 4; b++) begin rb(5, b == 3); step(); end
        chk("t2_noerr", int'(err_valid), 0);
        chk("t2_out0", int'(outstanding), 0);
        ar(5, 0); step(); rb(5, 1); step();
        chk("t2_cnt_reset", int'(err_valid), 0);

        // Early RLAST on beat 2 of 4
        ar(3, 3); step();
        rb(3, 0); step();
        rb(3, 1); step();
        chk("t3_valid", int'(err_valid), 1);
        chk("t3_code", int'(err_code), 2);
        chk("t3_id", int'(err_id), 3);
        step();
        chk("t3_one_pulse", int'(err_valid), 0);
        chk("t3_out0", int'(outstanding), 0);
        rb(3, 1, 2); step();
        chk("t3_empty_unexp", int'(err_code), 1);
        chk("t3_resp_cnt", int'(resp_err_cnt), 1);

        // Overflow on 5th push
        for (int k = 0; k < 5; k++) begin ar(7, 0); step(); end
        chk("t4_code", int'(err_code), 4);
        chk("t4_id", int'(err_id), 7);
        chk("t4_out", int'(outstanding), 4);
        for (int k = 0; k < 4; k++) begin rb(7, 1); step(); end
        chk("t4_drained", int'(outstanding), 0);

        // R before AR in the same cycle: UNEXPECTED, then next R passes
        ar(9, 0); rb(9, 1); step();
        chk("t5_code", int'(err_code), 1);
        chk("t5_id", int'(err_id), 9);
        rb(9, 1); step();
        chk("t5_pass", int'(err_valid), 0);
        chk("t5_out0", int'(outstanding), 0);

        // Missing RLAST
        ar(2, 1); step();
        rb(2, 0); step();
        rb(2, 0); step();
        chk("t6_code", int'(err_code), 3);
        chk("t6_id", int'(err_id), 2);

        // R error beats OVERFLOW; sticky holds both
        for (int k = 0; k < 4; k++) begin ar(4, 0); step(); end
        ar(4, 0); rb(6, 1); step();
        chk("t7_code", int'(err_code), 1);
        chk("t7_id", int'(err_id), 6);
        chk("t7_sticky", int'(err_sticky), 5'b01111);
        err_clear = 1; step();
        chk("t7_clear", int'(err_sticky), 0);
        err_clear = 1; rb(6, 1); step();
        chk("t7_clear_vs_err", int'(err_sticky), 5'b00001);
        for (int k = 0; k < 4; k++) begin rb(4, 1); step(); end

        // Same-cycle push and pop leave outstanding unchanged
        ar(1, 0); step();
        ar(1, 0); rb(1, 1); step();
        chk("t8_out_same", int'(outstanding), 1);
        rb(1, 1); step();

        // Reset mid-burst drops tracking
        ar(8, 2); step();
        rb(8, 0); step();
        rst = 0; step(); rst = 1;
        chk("t9_rst_out", int'(outstanding), 0);
        chk("t9_rst_sticky", int'(err_sticky), 0);
        rb(8, 1); step();
        chk("t9_code", int'(err_code), 1);
        chk("t9_id", int'(err_id), 8);

`ifdef AXI_RD_CHK_TIMEOUT_EN
        step();
        ar(1, 0); step();
        chk("t10_out1", int'(outstanding), 1);
        n = 0;
        while (n < 100) begin
            step(); n++;
            if (err_valid) break;
        end
        chk("t10_latency", n, TMO);
        chk("t10_code", int'(err_code), 5);
        chk("t10_id", int'(err_id), 0);
        chk("t10_sticky", int'(err_sticky[4]), 1);
        err_clear = 1; step();
        chk("t10_clear", int'(err_sticky), 0);
        rb(1, 1); step();
`else
        n = 0;
        repeat (5) begin step(); n += int'(err_sticky[4]); end
        chk("no_timeout_bit", n, 0);
`endif
        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axi_rd_order_checker.md
# axi_rd_order_checker

Synthesizable AXI read-channel ordering checker that passively monitors an AR handshake stream and the matching R stream on the master side of the reorder buffer. Per ARID it tracks outstanding bursts in order and checks that returned beats arrive in AXI per-ID order with correct beat count and RLAST placement. Errors are reported as a registered one-cycle event plus sticky status. It replaces bench-only scoreboarding with a reusable on-chip or bench-embedded monitor.

## Interface
- ID_WIDTH, 4: ARID/RID width; NUM_IDS = 2**ID_WIDTH tracked IDs.
- LEN_WIDTH, 8: ARLEN width; a burst has len+1 beats.
- PER_ID_DEPTH, 4: outstanding bursts per ID; power of two, at least 2.
- RESP_WIDTH, 2: RRESP width.
- TIMEOUT_CYCLES, 1000: watchdog limit; used only with the timeout feature.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- ar_valid, ar_ready  in  1  AR handshake being monitored.
- ar_id  in  ID_WIDTH  ARID.
- ar_len  in  LEN_WIDTH  ARLEN.
- r_valid, r_ready  in  1  R handshake being monitored.
- r_id  in  ID_WIDTH  RID.
- r_last  in  1  RLAST.
- r_resp  in  RESP_WIDTH  RRESP; nonzero values are counted only.
- err_clear  in  1  clears err_sticky.
- err_valid  out  1  one-cycle error pulse.
- err_code  out  3  0 NONE, 1 UNEXPECTED, 2 EARLY_LAST, 3 MISSING_LAST, 4 OVERFLOW, 5 TIMEOUT.
- err_id  out  ID_WIDTH  ID associated with the error.
- err_sticky  out  5  bit (code-1) set on every error of that code.
- outstanding  out  $clog2(NUM_IDS*PER_ID_DEPTH+1)  total tracked bursts.
- resp_err_cnt  out  16  beats with nonzero r_resp; saturates at 16'hFFFF.

## Operation
- AR handshake (ar_valid&ar_ready):
  - If the ar_id FIFO has space, push ar_len.
  - If it is full, drop the burst and raise OVERFLOW with err_id=ar_id.
- R handshake (r_valid&r_ready):
  - Look up the r_id FIFO head len L and the per-ID beat counter c.
  - FIFO empty: raise UNEXPECTED. No state changes.
  - c<L and r_last=1: raise EARLY_LAST. Pop the head and set c=0.
  - c==L and r_last=0: raise MISSING_LAST. Pop the head and set c=0.
  - c==L and r_last=1: correct end of burst. Pop the head and set c=0.
  - Otherwise: c=c+1.
- Same-cycle AR and R on the same ID: R is evaluated against the pre-cycle FIFO state, then the push is applied. Push and pop in the same cycle are both legal.
- A same-cycle push and pop leaves `outstanding` unchanged.
- Error priority within one cycle: R error > OVERFLOW > TIMEOUT.
  - err_code and err_id report the highest-priority error.
  - err_sticky records every error raised that cycle.
- err_clear zeroes err_sticky. An error raised in the same cycle wins: its bit is set.

## Timing
- All outputs are registered and appear 1 cycle after the causing handshake.
- `outstanding` reflects handshakes from the previous cycle.
- The block never drives handshake signals; zero back-pressure.
- Reset clears all FIFOs, beat counters and the watchdog.
- All outputs reset to 0: err_valid=0, err_code=0, err_id=0, err_sticky=0, outstanding=0, resp_err_cnt=0.
- Reset asserted mid-burst discards all tracking; the next R beat after reset reports UNEXPECTED.
- FIFO pointers wrap modulo PER_ID_DEPTH, with an extra bit to distinguish full from empty.

## Configuration
- AXI_RD_CHK_TIMEOUT_EN defined:
  - A 32-bit watchdog increments each cycle while outstanding!=0 and no R handshake occurs.
  - It clears on any R handshake or when outstanding==0.
  - On reaching TIMEOUT_CYCLES it raises TIMEOUT with err_id=0 and restarts from 0.
- Undefined: no watchdog logic is present; code 5 and err_sticky[4] are never produced.

## Structure
- Package axi_rd_chk_pkg holds:
  - err_code_t enum (3-bit) with the codes above.
  - ERR_CODE_WIDTH=3.
  - STICKY_WIDTH=5.
- Sub-module axi_rd_len_fifo: synchronous FIFO of LEN_WIDTH entries, PER_ID_DEPTH deep.
  - Ports: push, pop, head, full, empty.
  - Instantiated NUM_IDS times via generate.
- Beat counters: a NUM_IDS x LEN_WIDTH register array in the top module.

## Test plan
- AR id=0 len=0, then R id=0 last=1 -> no error; outstanding goes 1 then 0.
- AR id=5 len=3, then four R beats id=5 with last only on beat 4 -> no error; beat counter returns to 0.
- AR id=3 len=3, then R id=3 last=1 on beat 2 -> err_code=2, err_id=3, one pulse; FIFO for id 3 is empty.
- Five AR id=7 len=0 with PER_ID_DEPTH=4 -> 5th raises err_code=4, err_id=7; outstanding=4.
- R id=9 with no AR, in the same cycle as an AR id=9 -> err_code=1, err_id=9; the next R id=9 last=1 passes.
- With AXI_RD_CHK_TIMEOUT_EN and TIMEOUT_CYCLES=20: AR id=1 len=0 and no R -> err_code=5 exactly 20 cycles after outstanding becomes 1; err_clear then zeroes err_sticky.
